// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-port SPI_mnrch arbiter.
// Gyro command words live here so every requester uses the same encodings.
package spi_arb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      ARM    = 3'd2,
      BUSY   = 3'd3,
      RESP   = 3'd4
   } arb_state_e;

   localparam logic [15:0] CMD_ENABLE_INT = 16'h0D02;
   localparam logic [15:0] CMD_GYRO_SET   = 16'h1160;
   localparam logic [15:0] CMD_ROUND      = 16'h1440;
   // Yaw reads: low byte is don't-care, shown as zero.
   localparam logic [15:0] CMD_YAW_L      = 16'hA600;
   localparam logic [15:0] CMD_YAW_H      = 16'hA700;

   function automatic logic [15:0] eff_timeout(input logic [15:0] timeout, input bit fast_sim);
      return fast_sim ? (timeout >> 4) : timeout;
   endfunction

endpackage

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI_mnrch between two level-held requesters,
// with stale-done masking and a saturating transaction timeout.
module spi_arb
   import spi_arb_pkg::*;
#(
   parameter logic [15:0] TIMEOUT  = 16'd4096,
   parameter bit          FAST_SIM = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [15:0] cmd0,
   input  logic        req1,
   input  logic [15:0] cmd1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [15:0] rsp_data,
   output logic        gnt,
   output logic        busy,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rd
);

   localparam logic [15:0] TMO_LIM = eff_timeout(TIMEOUT, FAST_SIM);

   arb_state_e  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] cmd_q, cmd_d;
   logic [15:0] rsp_q, rsp_d;
   logic        gnt_q, gnt_d;
   logic        ptr_q, ptr_d;
   logic        win;
   logic        tmo;

   // With both ports requesting, the pointer names the port not served last.
   assign win = (req0 & req1) ? ptr_q : req1;
   assign tmo = ((state_q == ARM) || (state_q == BUSY)) && (cnt_q >= TMO_LIM);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      rsp_d   = rsp_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;

      if ((state_q == LAUNCH || state_q == ARM || state_q == BUSY) && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;

      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               gnt_d   = win;
               cmd_d   = win ? cmd1 : cmd0;
               cnt_d   = 16'd0;
               state_d = LAUNCH;
            end
         end
         LAUNCH: state_d = ARM;
         ARM: begin
            // Done is still high from the previous transfer until SPI_mnrch sees wrt.
            if (tmo) begin
               ptr_d   = ~gnt_q;
               state_d = IDLE;
            end else if (!spi_done) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (tmo) begin
               ptr_d   = ~gnt_q;
               state_d = IDLE;
            end else if (spi_done) begin
               rsp_d   = spi_rd;
               state_d = RESP;
            end
         end
         RESP: begin
            ptr_d   = ~gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         cmd_q   <= 16'h0000;
         rsp_q   <= 16'h0000;
         gnt_q   <= 1'b0;
         ptr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         rsp_q   <= rsp_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign done0    = (state_q == RESP) & ~gnt_q;
   assign done1    = (state_q == RESP) &  gnt_q;
   assign err0     = tmo & ~gnt_q;
   assign err1     = tmo &  gnt_q;
   assign spi_wrt  = (state_q == LAUNCH);
   assign busy     = (state_q != IDLE);
   assign gnt      = gnt_q;
   assign spi_cmd  = cmd_q;
   assign rsp_data = rsp_q;

endmodule

// File: tb/tb_spi_arb.sv
// Scoreboard bench for spi_arb: a behavioural SPI_mnrch answers each command,
// expected completions are queued as requests are raised and retired on done/err.
module tb_spi_arb;
   import spi_arb_pkg::*;

   localparam int XFER_LAT = 4;

   typedef struct packed {
      logic        port;
      logic        err;
      logic [15:0] cmd;
      logic [15:0] rsp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [15:0] cmd0, cmd1;
   logic        done0, done1, err0, err1;
   logic [15:0] rsp_data;
   logic        gnt, busy, spi_wrt;
   logic [15:0] spi_cmd;
   logic        spi_done;
   logic [15:0] spi_rd;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          req_cyc, wrt_cyc, rise_cyc;
   int          left0, left1;
   int          stale_gen = 0;
   int          stale_seen = 0;
   int          lat_cnt;
   bit          meas_wrt, hold_chk, hang, prev_done;
   logic [15:0] last_rsp;
   logic        wrt_s;
   logic [15:0] cmd_s, pend_rd;

   spi_arb #(.TIMEOUT(16'd4096), .FAST_SIM(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
      .done0(done0), .done1(done1), .err0(err0), .err1(err1),
      .rsp_data(rsp_data), .gnt(gnt), .busy(busy),
      .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
      .spi_done(spi_done), .spi_rd(spi_rd)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rd_of(input logic [15:0] c);
      return c ^ 16'hA6C3;
   endfunction

   // SPI_mnrch stand-in: done drops after wrt and rises XFER_LAT clocks later.
   initial begin
      spi_done = 1'b0;
      spi_rd   = 16'h0000;
      lat_cnt  = 0;
      pend_rd  = 16'h0000;
      forever begin
         @(negedge clk);
         wrt_s = spi_wrt;
         cmd_s = spi_cmd;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            spi_done = 1'b0;
            lat_cnt  = 0;
         end else if (wrt_s) begin
            spi_done = 1'b0;
            lat_cnt  = hang ? 0 : XFER_LAT;
            pend_rd  = rd_of(cmd_s);
         end else if (lat_cnt > 0) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0) begin
               spi_done = 1'b1;
               spi_rd   = pend_rd;
            end
         end else if (stale_seen != stale_gen) begin
            stale_seen = stale_gen;
            spi_done   = 1'b1;
            spi_rd     = 16'hBEEF;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic push(input logic port, input logic err, input logic [15:0] c);
      exp_t e;
      e.port = port;
      e.err  = err;
      e.cmd  = c;
      e.rsp  = err ? last_rsp : rd_of(c);
      if (!err) last_rsp = e.rsp;
      exp_q.push_back(e);
   endtask

   task automatic observe();
      exp_t e;
      if (spi_wrt) begin
         wrt_cyc = cyc;
         if (meas_wrt) begin
            chk("wrt_lat", cyc - req_cyc + 1, 2);
            meas_wrt = 1'b0;
         end
         if (exp_q.size() > 0) begin
            chk("wrt_cmd", 32'(spi_cmd), 32'(exp_q[0].cmd));
            chk("wrt_gnt", 32'(gnt), 32'(exp_q[0].port));
         end
      end
      if (hold_chk && busy) chk("cmd_hold", 32'(spi_cmd), 32'(CMD_ROUND));
      if (spi_done && !prev_done) rise_cyc = cyc;
      prev_done = spi_done;
      if (done0 | done1 | err0 | err1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'({done0, done1, err0, err1}), 0);
         end else begin
            e = exp_q.pop_front();
            chk("port", 32'(done1 | err1), 32'(e.port));
            chk("is_err", 32'(err0 | err1), 32'(e.err));
            chk("rsp_data", 32'(rsp_data), 32'(e.rsp));
            if (e.err) chk("tmo_lat", cyc - wrt_cyc, 256);
            else       chk("done_lat", cyc - rise_cyc + 1, 2);
         end
         if ((done0 | err0) && left0 > 0) begin
            left0--;
            if (left0 == 0) req0 = 1'b0;
         end
         if ((done1 | err1) && left1 > 0) begin
            left1--;
            if (left1 == 0) req1 = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      observe();
   endtask

   task automatic run_xfers(input int max_cyc);
      int n = 0;
      while ((left0 > 0 || left1 > 0 || busy) && n < max_cyc) begin
         tick();
         n++;
      end
      chk("drain", left0 + left1, 0);
      chk("sb_empty", exp_q.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_done0"}, 32'(done0), 0);
      chk({tag, "_done1"}, 32'(done1), 0);
      chk({tag, "_err0"}, 32'(err0), 0);
      chk({tag, "_err1"}, 32'(err1), 0);
      chk({tag, "_wrt"}, 32'(spi_wrt), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_gnt"}, 32'(gnt), 0);
      chk({tag, "_rsp"}, 32'(rsp_data), 0);
      chk({tag, "_cmd"}, 32'(spi_cmd), 0);
   endtask

   initial begin
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; cmd0 = 16'h0; cmd1 = 16'h0;
      hang = 1'b0; meas_wrt = 1'b0; hold_chk = 1'b0; prev_done = 1'b0;
      left0 = 0; left1 = 0; last_rsp = 16'h0000;
      req_cyc = 0; wrt_cyc = 0; rise_cyc = 0;
      repeat (3) tick();
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      tick();

      // Both ports held from reset: grants alternate starting with port 0.
      cmd0 = CMD_ENABLE_INT; cmd1 = CMD_GYRO_SET;
      push(1'b0, 1'b0, CMD_ENABLE_INT);
      push(1'b1, 1'b0, CMD_GYRO_SET);
      push(1'b0, 1'b0, CMD_ENABLE_INT);
      push(1'b1, 1'b0, CMD_GYRO_SET);
      left0 = 2; left1 = 2; req0 = 1'b1; req1 = 1'b1;
      run_xfers(300);

      // Single yaw read with request-to-wrt latency.
      cmd0 = CMD_YAW_L;
      push(1'b0, 1'b0, CMD_YAW_L);
      left0 = 1; meas_wrt = 1'b1; req_cyc = cyc; req0 = 1'b1;
      run_xfers(200);
      chk("rsp_yaw_l", 32'(rsp_data), 32'h00C3);

      // Stale done with a different rd word parked on the bus.
      stale_gen++;
      repeat (3) tick();
      cmd0 = CMD_YAW_H;
      push(1'b0, 1'b0, CMD_YAW_H);
      left0 = 1; req0 = 1'b1;
      run_xfers(200);
      chk("rsp_stale", 32'(rsp_data), 32'h01C3);

      // Command changes after the grant must not reach the bus.
      hold_chk = 1'b1;
      cmd1 = CMD_ROUND;
      push(1'b1, 1'b0, CMD_ROUND);
      left1 = 1; req1 = 1'b1;
      tick();
      cmd1 = 16'hFFFF;
      run_xfers(200);
      hold_chk = 1'b0;

      // Hung transfer on port 1, then a normal port 0 transfer.
      hang = 1'b1;
      cmd1 = CMD_GYRO_SET;
      push(1'b1, 1'b1, CMD_GYRO_SET);
      left1 = 1; req1 = 1'b1;
      run_xfers(400);
      chk("busy_after_err", 32'(busy), 0);
      chk("rsp_after_err", 32'(rsp_data), 32'(last_rsp));
      hang = 1'b0;
      cmd0 = CMD_YAW_L;
      push(1'b0, 1'b0, CMD_YAW_L);
      left0 = 1; req0 = 1'b1;
      run_xfers(200);

      // Reset while port 1 sits in BUSY.
      hang = 1'b1;
      cmd1 = CMD_ROUND;
      left1 = 1; req1 = 1'b1;
      repeat (6) tick();
      chk("pre_rst_busy", 32'(busy), 1);
      chk("pre_rst_gnt", 32'(gnt), 1);
      rst_n = 1'b0; req1 = 1'b0; left1 = 0;
      #1;
      chk_reset_outputs("midrst");
      last_rsp = 16'h0000;
      repeat (2) tick();
      rst_n = 1'b1; hang = 1'b0;
      tick();
      cmd0 = CMD_ENABLE_INT;
      push(1'b0, 1'b0, CMD_ENABLE_INT);
      left0 = 1; req0 = 1'b1;
      run_xfers(200);
      chk("rsp_after_rst", 32'(rsp_data), 32'(rd_of(CMD_ENABLE_INT)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
